// File: rtl/dpram_bytemask_sync.sv
// dpram_bytemask_sync: simple dual-port RAM (one read port, one write port,
// single clock) with per-byte write enables and a zero-fill sweep that runs
// after every reset.
//
// Parameters
//   DEPTH      number of memory words (DEPTH <= 2**ADDR_WIDTH)
//   ADDR_WIDTH address width in bits
//   BYTES      bytes per word, word width W = 8*BYTES
//   OUT_REG    1 adds an output register stage (read latency 1+OUT_REG)
//   RDW_MODE   0 = read-old-data, 1 = forward merged write data on collision
//
// Ports
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   re_i         read request
//   raddr_i      read address
//   rdata_o      read data, holds its value between rvalid_o pulses
//   rvalid_o     one-cycle pulse marking valid rdata_o
//   we_i         write request
//   waddr_i      write address
//   wdata_i      write data
//   wbytemask_i  per-byte write enable, bit k covers wdata_i[8k+7:8k]
//   busy_o       high while the zero-fill sweep runs
module dpram_bytemask_sync #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int BYTES      = 4,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [8*BYTES-1:0]    rdata_o,
  output logic                  rvalid_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [8*BYTES-1:0]    wdata_i,
  input  logic [BYTES-1:0]      wbytemask_i,
  output logic                  busy_o
);

  localparam int W     = 8 * BYTES;
  // Index width just wide enough for the array, so the upper address bits
  // only take part in the range check.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_nx_s;

  logic [W-1:0] mem [DEPTH];

  logic             raddr_ok_s;
  logic             waddr_ok_s;
  logic [IDX_W-1:0] ridx_s;
  logic [IDX_W-1:0] widx_s;
  logic             port_we_s;
  logic             port_re_s;
  logic [W-1:0]     read_word_s;

  logic             rvalid1_r;
  logic [W-1:0]     rdata1_r;

  // Replace the bytes of old_word selected by mask with those of new_word.
  function automatic logic [W-1:0] merge_bytes(input logic [W-1:0]     old_word,
                                               input logic [W-1:0]     new_word,
                                               input logic [BYTES-1:0] mask);
    logic [W-1:0] res;
    res = old_word;
    for (int k = 0; k < BYTES; k++) begin
      if (mask[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Sweep state and counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= INIT;
      cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state logic: INIT walks cnt over every word, then hands over to READY.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      INIT: begin
        if (cnt_r == LAST_IDX) begin
          state_nx_s = READY;
          cnt_nx_s   = {IDX_W{1'b0}};
        end else begin
          cnt_nx_s   = cnt_r + IDX_W'(1);
        end
      end
      READY: begin
        state_nx_s = READY;
        cnt_nx_s   = {IDX_W{1'b0}};
      end
      default: begin
        state_nx_s = INIT;
        cnt_nx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  assign busy_o = (state_r == INIT);

  // Port qualification: ports only act in READY, and an all-zero mask counts
  // as no write at all (so it is neither stored nor forwarded).
  always_comb begin
    raddr_ok_s = ({1'b0, raddr_i} < DEPTH_CMP);
    waddr_ok_s = ({1'b0, waddr_i} < DEPTH_CMP);
    ridx_s     = raddr_i[IDX_W-1:0];
    widx_s     = waddr_i[IDX_W-1:0];
    port_re_s  = (state_r == READY) && re_i;
    port_we_s  = (state_r == READY) && we_i && waddr_ok_s && (|wbytemask_i);
  end

  // Read word selection, including optional same-address forwarding.
  always_comb begin
    read_word_s = {W{1'b0}};
    if (raddr_ok_s) begin
      if ((RDW_MODE == 1) && port_we_s && (waddr_i == raddr_i)) begin
        read_word_s = merge_bytes(mem[ridx_s], wdata_i, wbytemask_i);
      end else begin
        read_word_s = mem[ridx_s];
      end
    end else begin
      read_word_s = {W{1'b0}};
    end
  end

  // Memory array: zero fill during INIT, masked port writes in READY,
  // nothing while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_r == INIT) begin
        mem[cnt_r] <= {W{1'b0}};
      end else if (port_we_s) begin
        for (int k = 0; k < BYTES; k++) begin
          if (wbytemask_i[k]) begin
            mem[widx_s][8*k +: 8] <= wdata_i[8*k +: 8];
          end
        end
      end
    end
  end

  // First read stage; data only updates on an accepted read so it holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid1_r <= 1'b0;
      rdata1_r  <= {W{1'b0}};
    end else begin
      rvalid1_r <= port_re_s;
      if (port_re_s) begin
        rdata1_r <= read_word_s;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic         rvalid2_r;
      logic [W-1:0] rdata2_r;

      // Optional output stage, again loaded only when stage one is valid.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rvalid2_r <= 1'b0;
          rdata2_r  <= {W{1'b0}};
        end else begin
          rvalid2_r <= rvalid1_r;
          if (rvalid1_r) begin
            rdata2_r <= rdata1_r;
          end
        end
      end

      assign rvalid_o = rvalid2_r;
      assign rdata_o  = rdata2_r;
    end else begin : g_no_out_reg
      assign rvalid_o = rvalid1_r;
      assign rdata_o  = rdata1_r;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_bytemask_sync.sv
// Scoreboard bench for dpram_bytemask_sync with DEPTH=16. Two instances share
// the stimulus: inst A (OUT_REG=0, RDW_MODE=0) and inst B (OUT_REG=1,
// RDW_MODE=1). Expected read results are queued at issue time with the cycle
// they are due; a monitor pops and compares on every rvalid_o pulse.
module tb_dpram_bytemask_sync;

  localparam int DEPTH = 16;
  localparam int AW    = 9;
  localparam int BY    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          re = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [31:0]   wdata = '0;
  logic [BY-1:0] wmask = '0;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  logic [31:0] model [DEPTH];
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;
  logic        rst_q = 1'b1;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  dpram_bytemask_sync #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BYTES(BY),
                        .OUT_REG(0), .RDW_MODE(0)) u_a (
    .clk_i(clk), .rst_i(rst), .re_i(re), .raddr_i(raddr),
    .rdata_o(rdata_a), .rvalid_o(rvalid_a), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .wbytemask_i(wmask), .busy_o(busy_a));

  dpram_bytemask_sync #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BYTES(BY),
                        .OUT_REG(1), .RDW_MODE(1)) u_b (
    .clk_i(clk), .rst_i(rst), .re_i(re), .raddr_i(raddr),
    .rdata_o(rdata_b), .rvalid_o(rvalid_b), .we_i(we), .waddr_i(waddr),
    .wdata_i(wdata), .wbytemask_i(wmask), .busy_o(busy_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor: compare each rvalid pulse against the queue head, check that
  // rdata holds between pulses, and flag expected reads that never arrived.
  task automatic mon(input int id, input logic v, input logic [31:0] d);
    exp_t        e;
    logic [31:0] last;
    int          n;
    last = (id == 0) ? last_a : last_b;
    n    = (id == 0) ? qa.size() : qb.size();
    if (rst_q) begin
      if (v !== 1'b0 || d !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_out inst%0d: rvalid=%b rdata=%h, required 0/00000000", id, v, d);
      end
      last = 32'h0;
    end else if (v === 1'b1) begin
      if (n == 0) begin
        miscompares++;
        $display("FAIL unexpected_rvalid inst%0d cyc %0d: rdata=%h, no read pending", id, cyc, d);
      end else begin
        if (id == 0) e = qa.pop_front(); else e = qb.pop_front();
        vectors++;
        if (d !== e.d || cyc != e.due) begin
          miscompares++;
          $display("FAIL read_data inst%0d: got %h at cyc %0d, required %h at cyc %0d",
                   id, d, cyc, e.d, e.due);
        end
      end
      last = d;
    end else begin
      if (d !== last) begin
        miscompares++;
        $display("FAIL rdata_hold inst%0d cyc %0d: rdata=%h, required %h", id, cyc, d, last);
      end
      if (n != 0) begin
        e = (id == 0) ? qa[0] : qb[0];
        if (e.due < cyc) begin
          if (id == 0) void'(qa.pop_front()); else void'(qb.pop_front());
          vectors++;
          miscompares++;
          $display("FAIL missing_rvalid inst%0d: data %h due cyc %0d, none by cyc %0d",
                   id, e.d, e.due, cyc);
        end
      end
    end
    if (id == 0) last_a = last; else last_b = last;
  endtask

  always @(negedge clk) begin
    mon(0, rvalid_a, rdata_a);
    mon(1, rvalid_b, rdata_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a < AW'(DEPTH)) r = model[a[3:0]];
    return r;
  endfunction

  // Queue one read for both instances (latency 1 for A, 2 for B).
  task automatic push_read(input logic [AW-1:0] a);
    exp_t e;
    e.d = model_rd(a);
    e.due = cyc + 1; qa.push_back(e);
    e.due = cyc + 2; qb.push_back(e);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; waddr = a; wdata = d; wmask = m;
    if (a < AW'(DEPTH)) model[a[3:0]] = merge(model[a[3:0]], d, m);
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    re = 1'b1; raddr = a;
    push_read(a);
    tick();
    re = 1'b0;
  endtask

  // Back-to-back reads of addresses lo..hi.
  task automatic read_burst(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      re = 1'b1; raddr = AW'(i);
      push_read(AW'(i));
      tick();
    end
    re = 1'b0;
  endtask

  // Same-cycle read and write of one address with hand-computed results.
  task automatic collide(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] exp_old, input logic [31:0] exp_fwd);
    exp_t e;
    re = 1'b1; raddr = a; we = 1'b1; waddr = a; wdata = d; wmask = m;
    e.d = exp_old; e.due = cyc + 1; qa.push_back(e);
    e.d = exp_fwd; e.due = cyc + 2; qb.push_back(e);
    model[a[3:0]] = merge(model[a[3:0]], d, m);
    tick();
    re = 1'b0; we = 1'b0;
  endtask

  // Count busy cycles after rst has just been released; optionally drive
  // port traffic late in the sweep, which must be ignored.
  task automatic count_busy(input string name, input bit poke);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b1 || busy_b !== 1'b1) break;
      n++;
      if (poke && n == 12) begin
        we = 1'b1; waddr = '0; wdata = 32'hDEADBEEF; wmask = 4'hF;
        re = 1'b1; raddr = '0;
      end else begin
        we = 1'b0; re = 1'b0;
      end
    end
    we = 1'b0; re = 1'b0;
    vectors++;
    if (n != DEPTH || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy for %0d cycles (end a=%b b=%b), required %0d then 0",
               name, n, busy_a, busy_b, DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      tick();
    end
    tick();
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d reads still pending, required 0/0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  logic [31:0] burst_vals [8];

  initial begin
    burst_vals[0] = 32'h0F1E2D3C; burst_vals[1] = 32'h11111111;
    burst_vals[2] = 32'h80000001; burst_vals[3] = 32'hCAFEF00D;
    burst_vals[4] = 32'h12345678; burst_vals[5] = 32'hFFFF0000;
    burst_vals[6] = 32'h00FF00FF; burst_vals[7] = 32'h7E7E7E7E;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Reset, sweep length, port traffic ignored during INIT.
    tick(); tick();
    rst = 1'b0;
    count_busy("busy_after_reset", 1'b1);
    read_burst(0, DEPTH - 1);
    drain();

    // Masked partial overwrite: AABBCCDD then 11223344 mask 0101 -> AA22CC44.
    do_write(AW'(5), 32'hAABBCCDD, 4'b1111);
    do_write(AW'(5), 32'h11223344, 4'b0101);
    begin : chk5
      exp_t e;
      re = 1'b1; raddr = AW'(5);
      e.d = 32'hAA22CC44; e.due = cyc + 1; qa.push_back(e);
      e.due = cyc + 2; qb.push_back(e);
      tick();
      re = 1'b0;
    end
    drain();

    // Collision at addr 3: old data for A, forwarded 0000FFFF for B.
    collide(AW'(3), 32'hFFFFFFFF, 4'b0011, 32'h00000000, 32'h0000FFFF);
    do_read(AW'(3));
    // Zero-mask collision: nothing stored, nothing forwarded.
    collide(AW'(6), 32'h12345678, 4'b0000, 32'h00000000, 32'h00000000);
    do_read(AW'(6));
    drain();

    // Fill 0..7 then eight back-to-back reads.
    for (int i = 0; i < 8; i++) do_write(AW'(i), burst_vals[i], 4'hF);
    read_burst(0, 7);
    drain();

    // Out-of-range write and read; 20 aliases to 4 if bits were dropped.
    do_write(AW'(20), 32'hDEADBEEF, 4'hF);
    do_read(AW'(20));
    do_read(AW'(300));
    read_burst(0, DEPTH - 1);
    drain();

    // Read in flight, then a 1-cycle reset: A has already answered, B drops it.
    begin : inflight
      exp_t e;
      re = 1'b1; raddr = AW'(2);
      e.d = 32'h80000001; e.due = cyc + 1; qa.push_back(e);
      tick();
      re = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    // Reset again at sweep cycle 7: full sweep restarts.
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("busy_after_midsweep_reset", 1'b0);
    read_burst(0, DEPTH - 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
